// File: rtl/u_rec.sv
// u_rec: UART receive engine with a 3-sample majority vote per bit.
// Recovers WORD_LEN-bit, LSB-first frames with one start and one stop bit.
module u_rec #(
    parameter int WORD_LEN = 8,
    parameter int BIT_CELL = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_recH,
    output logic [7:0] rec_dataH,
    output logic       rec_readyH,
    output logic       frame_errH,
    output logic       rec_busyH
);

    localparam int CW    = $clog2(BIT_CELL);
    localparam int MID   = BIT_CELL / 2;
    localparam int SHAMT = 8 - WORD_LEN;

    localparam logic [CW-1:0] CELL_VOTE_A = CW'(MID - 1);
    localparam logic [CW-1:0] CELL_VOTE_B = CW'(MID);
    localparam logic [CW-1:0] CELL_DECIDE = CW'(MID + 1);
    localparam logic [CW-1:0] CELL_END    = CW'(BIT_CELL - 1);
    localparam logic [CW-1:0] CELL_ONE    = CW'(1);
    localparam logic [2:0]    LAST_BIT    = 3'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          rx_meta;
    logic          rx_s;
    logic          armed;
    logic          vote_a;
    logic          vote_b;
    logic          vote;
    logic [CW-1:0] cell_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          at_decide;
    logic          at_end;
    logic          strobe;
    logic          shift_en;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign at_decide = (cell_cnt == CELL_DECIDE);
    assign at_end    = (cell_cnt == CELL_END);
    assign vote      = maj3(vote_a, vote_b, rx_s);

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_recH;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    next_state = START;
                end else begin
                    next_state = IDLE;
                end
            end
            START: begin
                if (at_decide && vote) begin
                    next_state = IDLE;
                end else if (at_end) begin
                    next_state = DATA;
                end else begin
                    next_state = START;
                end
            end
            DATA: begin
                if (at_end && (bit_cnt == LAST_BIT)) begin
                    next_state = STOP;
                end else begin
                    next_state = DATA;
                end
            end
            STOP: begin
                // Leave at mid stop bit so the next start edge is never missed
                if (at_decide) begin
                    next_state = IDLE;
                end else begin
                    next_state = STOP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        strobe   = 1'b0;
        shift_en = 1'b0;
        case (state)
            DATA:    shift_en = at_decide;
            STOP:    strobe   = at_decide;
            default: begin
                strobe   = 1'b0;
                shift_en = 1'b0;
            end
        endcase
    end

    // Bit timing, vote sampling and shift register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            armed    <= 1'b0;
            cell_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            vote_a   <= 1'b0;
            vote_b   <= 1'b0;
        end else begin
            // A line stuck low must go high once before a start edge counts
            armed <= (state == IDLE) && rx_s;

            if ((state == IDLE) || (next_state == IDLE) || at_end) begin
                cell_cnt <= '0;
            end else begin
                cell_cnt <= cell_cnt + CELL_ONE;
            end

            if (state == START) begin
                bit_cnt <= 3'd0;
            end else if ((state == DATA) && at_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if ((state != IDLE) && (cell_cnt == CELL_VOTE_A)) begin
                vote_a <= rx_s;
            end
            if ((state != IDLE) && (cell_cnt == CELL_VOTE_B)) begin
                vote_b <= rx_s;
            end

            if (shift_en) begin
                shift <= {vote, shift[7:1]};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rec_dataH  <= 8'd0;
            rec_readyH <= 1'b0;
            frame_errH <= 1'b0;
            rec_busyH  <= 1'b0;
        end else begin
            rec_readyH <= strobe;
            rec_busyH  <= (next_state != IDLE);
            if (strobe) begin
                rec_dataH  <= shift >> SHAMT;
                frame_errH <= ~vote;
            end
        end
    end

endmodule

// File: tb/tb_u_rec.sv
// Directed testbench for u_rec: framed bytes, false starts, framing errors,
// back-to-back frames, glitch rejection and mid-frame reset.
module tb_u_rec;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       line    = 1'b1;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       frame_errH;
    logic       rec_busyH;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_strobe = 0;
    int         n_wide   = 0;
    int         last_cyc = 0;
    int         prev_cyc = 0;
    int         fall_cyc = 0;
    int         base;
    logic       ready_prev = 1'b0;
    logic [7:0] pat;

    u_rec #(.WORD_LEN(8), .BIT_CELL(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_recH  (line),
        .rec_dataH  (rec_dataH),
        .rec_readyH (rec_readyH),
        .frame_errH (frame_errH),
        .rec_busyH  (rec_busyH)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses, timestamps them and flags multi-cycle pulses
    always @(negedge sys_clk) begin
        if (rec_readyH) begin
            n_strobe <= n_strobe + 1;
            prev_cyc <= last_cyc;
            last_cyc <= cyc;
            if (ready_prev) n_wide <= n_wide + 1;
        end
        ready_prev <= rec_readyH;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Drives one frame at 16 cycles/bit; optional one-cycle glitch mid data bit
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input int glitch_bit, input bit chk_busy);
        fall_cyc = cyc;
        line = 1'b0;
        tick(16);
        if (chk_busy) check("busy_in_frame", rec_busyH, 1'b1);
        for (int i = 0; i < 8; i++) begin
            line = data[i];
            if (glitch_bit == i) begin
                tick(9);
                line = ~data[i];
                tick(1);
                line = data[i];
                tick(6);
            end else begin
                tick(16);
            end
        end
        line = stop_val;
        tick(16);
        if (chk_busy) check("busy_after_frame", rec_busyH, 1'b0);
    endtask

    initial begin
        // 1: reset, idle line
        tick(3);
        check("rst_data", rec_dataH, 8'h00);
        check("rst_busy", rec_busyH, 1'b0);
        sys_rst = 1'b0;
        tick(50);
        check("idle_data", rec_dataH, 8'h00);
        check("idle_err", frame_errH, 1'b0);
        check("idle_ready", rec_readyH, 1'b0);
        check("idle_busy", rec_busyH, 1'b0);
        check("idle_strobes", n_strobe, 0);

        // 2: 0xA5 with latency and busy checks
        send_frame(8'hA5, 1'b1, -1, 1'b1);
        check("a5_strobes", n_strobe, 1);
        check("a5_data", rec_dataH, 8'hA5);
        check("a5_err", frame_errH, 1'b0);
        check("a5_latency_ok", ((last_cyc - fall_cyc) >= 154) && ((last_cyc - fall_cyc) <= 158), 1'b1);
        tick(10);

        // 3: 4-cycle low glitch is a false start, then 0x3C
        line = 1'b0;
        tick(4);
        line = 1'b1;
        tick(30);
        check("glitch_strobes", n_strobe, 1);
        check("glitch_busy", rec_busyH, 1'b0);
        check("glitch_data_kept", rec_dataH, 8'hA5);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        check("3c_strobes", n_strobe, 2);
        check("3c_data", rec_dataH, 8'h3C);
        tick(10);

        // 4: framing error, line held low, then recovery with 0xFF
        send_frame(8'h00, 1'b0, -1, 1'b0);
        check("ferr_strobes", n_strobe, 3);
        check("ferr_data", rec_dataH, 8'h00);
        check("ferr_err", frame_errH, 1'b1);
        tick(200);
        check("break_strobes", n_strobe, 3);
        check("break_busy", rec_busyH, 1'b0);
        check("break_err_held", frame_errH, 1'b1);
        line = 1'b1;
        tick(20);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        check("ff_strobes", n_strobe, 4);
        check("ff_data", rec_dataH, 8'hFF);
        check("ff_err", frame_errH, 1'b0);
        tick(10);

        // 5: back-to-back frames, clean and with one-cycle glitches
        send_frame(8'h12, 1'b1, -1, 1'b0);
        check("b2b_12_data", rec_dataH, 8'h12);
        send_frame(8'h34, 1'b1, -1, 1'b0);
        check("b2b_34_data", rec_dataH, 8'h34);
        check("b2b_strobes", n_strobe, 6);
        check("b2b_spacing", last_cyc - prev_cyc, 160);
        send_frame(8'h12, 1'b1, 1, 1'b0);
        check("vote_12_data", rec_dataH, 8'h12);
        send_frame(8'h34, 1'b1, 3, 1'b0);
        check("vote_34_data", rec_dataH, 8'h34);
        check("vote_err", frame_errH, 1'b0);
        check("vote_strobes", n_strobe, 8);
        check("vote_spacing", last_cyc - prev_cyc, 160);
        tick(10);

        // 6: reset in the middle of 0x55 data bits, then 0x81
        pat = 8'h55;
        base = n_strobe;
        line = 1'b0;
        tick(16);
        for (int i = 0; i < 3; i++) begin
            line = pat[i];
            tick(16);
        end
        line = pat[3];
        tick(8);
        check("pre_rst_busy", rec_busyH, 1'b1);
        sys_rst = 1'b1;
        tick(2);
        check("mid_rst_data", rec_dataH, 8'h00);
        check("mid_rst_busy", rec_busyH, 1'b0);
        sys_rst = 1'b0;
        line = 1'b1;
        tick(40);
        check("post_rst_strobes", n_strobe, base);
        check("post_rst_data", rec_dataH, 8'h00);
        check("post_rst_err", frame_errH, 1'b0);
        check("post_rst_busy", rec_busyH, 1'b0);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        check("81_data", rec_dataH, 8'h81);
        check("81_strobes", n_strobe, base + 1);
        tick(10);

        check("ready_one_cycle", n_wide, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
